// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg : valid/ready pipeline register with optional skid entry,
//                  flush-to-bubble and a saturating count of flushed beats.
// Rev 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int                 ADDR_W  = 16,
  parameter int                 INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP     = 16'h0000,
  parameter bit                 SKID    = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [ADDR_W-1:0]  in_opc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_opc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   flush_drops
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, opc_q, opc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d, skid_opc_q, skid_opc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [CNT_W-1:0]   drops_q, drops_d;

  logic               w_in_fire;
  logic               w_out_fire;
  logic [1:0]         w_drops;
  logic [CNT_W+1:0]   w_drop_sum;

  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = in_ready_q;
    end else begin : g_comb_ready
      assign in_ready = out_ready | ~out_valid_q;
    end
  endgenerate

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid_q & out_ready;

  // A beat leaving on the flush edge was delivered, so it is not a drop.
  assign w_drops    = {1'b0, out_valid_q & ~w_out_fire}
                    + {1'b0, state_q == ST_FULL}
                    + {1'b0, w_in_fire};
  assign w_drop_sum = {2'b00, drops_q} + {{CNT_W{1'b0}}, w_drops};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    opc_d        = opc_q;
    instr_d      = instr_q;
    skid_pc_d    = skid_pc_q;
    skid_opc_d   = skid_opc_q;
    skid_instr_d = skid_instr_q;
    drops_d      = drops_q;

    if (flush) begin
      state_d = ST_EMPTY;
      drops_d = (w_drop_sum > {2'b00, c_cnt_max}) ? c_cnt_max : w_drop_sum[CNT_W-1:0];
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (w_in_fire) begin
            pc_d    = in_pc;
            opc_d   = in_opc;
            instr_d = in_instr;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            pc_d    = in_pc;
            opc_d   = in_opc;
            instr_d = in_instr;
          end else if (w_in_fire) begin
            skid_pc_d    = in_pc;
            skid_opc_d   = in_opc;
            skid_instr_d = in_instr;
            state_d      = ST_FULL;
          end else if (w_out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            pc_d    = skid_pc_q;
            opc_d   = skid_opc_q;
            instr_d = skid_instr_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Bubble: the instruction field reads NOP whenever nothing is valid.
    if (state_d == ST_EMPTY) begin
      instr_d = NOP;
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      pc_q         <= '0;
      opc_q        <= '0;
      instr_q      <= NOP;
      skid_pc_q    <= '0;
      skid_opc_q   <= '0;
      skid_instr_q <= '0;
      drops_q      <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      pc_q         <= pc_d;
      opc_q        <= opc_d;
      instr_q      <= instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_opc_q   <= skid_opc_d;
      skid_instr_q <= skid_instr_d;
      drops_q      <= drops_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = pc_q;
  assign out_opc     = opc_q;
  assign out_instr   = instr_q;
  assign flush_drops = drops_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_reg : three pipe_stage_reg variants (SKID=1, SKID=0, CNT_W=2)
//                     driven in parallel and compared against a FIFO model.
// Rev 1.0
// ============================================================================
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_pc = '0;
  logic [15:0] in_opc = '0;
  logic [15:0] in_instr = '0;

  logic [2:0]  ov, ir;
  logic [15:0] o_pc [3];
  logic [15:0] o_opc [3];
  logic [15:0] o_instr [3];
  logic [7:0]  fd0, fd1;
  logic [1:0]  fd2;
  logic [57:0] obs [3];

  int ntot = 0;
  int npass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.ADDR_W(16), .INSTR_W(16), .NOP(16'h0000), .SKID(1'b1), .CNT_W(8)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_pc(in_pc), .in_opc(in_opc), .in_instr(in_instr), .out_valid(ov[0]), .out_ready(out_ready),
    .out_pc(o_pc[0]), .out_opc(o_opc[0]), .out_instr(o_instr[0]), .flush_drops(fd0));

  pipe_stage_reg #(.ADDR_W(16), .INSTR_W(16), .NOP(16'h0000), .SKID(1'b0), .CNT_W(8)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_pc(in_pc), .in_opc(in_opc), .in_instr(in_instr), .out_valid(ov[1]), .out_ready(out_ready),
    .out_pc(o_pc[1]), .out_opc(o_opc[1]), .out_instr(o_instr[1]), .flush_drops(fd1));

  pipe_stage_reg #(.ADDR_W(16), .INSTR_W(16), .NOP(16'h0000), .SKID(1'b1), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_pc(in_pc), .in_opc(in_opc), .in_instr(in_instr), .out_valid(ov[2]), .out_ready(out_ready),
    .out_pc(o_pc[2]), .out_opc(o_opc[2]), .out_instr(o_instr[2]), .flush_drops(fd2));

  assign obs[0] = {ov[0], o_pc[0], o_opc[0], o_instr[0], ir[0], fd0};
  assign obs[1] = {ov[1], o_pc[1], o_opc[1], o_instr[1], ir[1], fd1};
  assign obs[2] = {ov[2], o_pc[2], o_opc[2], o_instr[2], ir[2], 6'd0, fd2};

  // Reference model: each stage is a bounded FIFO (2 deep with skid, 1 without)
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] opc;
    logic [15:0] instr;
  } beat_t;

  typedef struct packed {
    logic [1:0]  sz;
    beat_t       b0;
    beat_t       b1;
    logic [15:0] spc;
    logic [15:0] sopc;
    logic [7:0]  cnt;
  } mstate_t;

  mstate_t ms [3];

  function automatic bit has_skid(input int i);
    return (i != 1);
  endfunction

  function automatic int cnt_max(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic logic model_ready(input int i);
    if (has_skid(i)) return (ms[i].sz < 2'd2);
    return out_ready || (ms[i].sz == 2'd0);
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int i);
    mstate_t n;
    logic    rdy, inf, outf;
    beat_t   nb;
    int      d, c;
    n    = s;
    rdy  = has_skid(i) ? (s.sz < 2'd2) : (out_ready || s.sz == 2'd0);
    inf  = in_valid && rdy;
    outf = (s.sz != 2'd0) && out_ready;
    nb   = '{pc: in_pc, opc: in_opc, instr: in_instr};
    if (flush) begin
      d = ((s.sz != 2'd0 && !outf) ? 1 : 0) + ((s.sz == 2'd2) ? 1 : 0) + (inf ? 1 : 0);
      c = int'(s.cnt) + d;
      if (c > cnt_max(i)) c = cnt_max(i);
      n.cnt = c[7:0];
      n.sz  = 2'd0;
    end else begin
      if (outf) begin
        n.b0 = s.b1;
        n.sz = s.sz - 2'd1;
      end
      if (inf) begin
        if (n.sz == 2'd0) n.b0 = nb;
        else n.b1 = nb;
        n.sz = n.sz + 2'd1;
      end
    end
    if (n.sz != 2'd0) begin
      n.spc  = n.b0.pc;
      n.sopc = n.b0.opc;
    end
    return n;
  endfunction

  function automatic logic [57:0] exp_vec(input int i);
    logic v;
    v = (ms[i].sz != 2'd0);
    return {v, ms[i].spc, ms[i].sopc, v ? ms[i].b0.instr : 16'h0000, model_ready(i), ms[i].cnt};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) ms[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) ms[i] <= mstep(ms[i], i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_opc    = pc + 16'd2;
    in_instr  = pc ^ 16'hA5C3;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic rst_pulse();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    ntot++;
    if (ov !== 3'b000 || o_instr[0] !== 16'h0 || fd0 !== 8'd0 || ir !== 3'b111)
      $display("FAIL reset_const: got ov=%b ir=%b instr=%h fd=%0d want ov=000 ir=111 instr=0000 fd=0",
               ov, ir, o_instr[0], fd0);
    else npass++;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ntot++;
      if (obs[i] !== exp_vec(i)) $display("FAIL reset dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      else npass++;
    end
  endtask

  task automatic test_stream();
    rst_pulse();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'(2 * k), 1'b1, 1'b0);
      tick();
      ntot++;
      if (ov[0] !== 1'b1 || o_pc[0] !== 16'(2 * k) || ir[0] !== 1'b1)
        $display("FAIL stream_pc[%0d]: got v=%b pc=%h rdy=%b want v=1 pc=%h rdy=1", k, ov[0], o_pc[0], ir[0], 16'(2 * k));
      else npass++;
      for (int i = 0; i < 3; i++) begin
        ntot++;
        if (obs[i] !== exp_vec(i)) $display("FAIL stream[%0d] dut%0d: got %h want %h", k, i, obs[i], exp_vec(i));
        else npass++;
      end
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_stall();
    rst_pulse();
    drive(1'b1, 16'h0010, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0012, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    ntot++;
    if (ir[0] !== 1'b0 || o_pc[0] !== 16'h0010 || ov[0] !== 1'b1)
      $display("FAIL stall_full: got rdy=%b pc=%h v=%b want rdy=0 pc=0010 v=1", ir[0], o_pc[0], ov[0]);
    else npass++;
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        ntot++;
        if (obs[i] !== exp_vec(i)) $display("FAIL stall[%0d] dut%0d: got %h want %h", k, i, obs[i], exp_vec(i));
        else npass++;
      end
      if (k == 0) begin
        ntot++;
        if (o_pc[0] !== 16'h0012 || ir[0] !== 1'b1)
          $display("FAIL stall_drain: got pc=%h rdy=%b want pc=0012 rdy=1", o_pc[0], ir[0]);
        else npass++;
      end
    end
  endtask

  task automatic test_flush_full();
    rst_pulse();
    drive(1'b1, 16'h0030, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0032, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0034, 1'b0, 1'b1);
    tick();
    ntot++;
    if (ov[0] !== 1'b0 || o_instr[0] !== 16'h0000 || fd0 !== 8'd2 || ir[0] !== 1'b1 || o_pc[0] !== 16'h0030)
      $display("FAIL flush_full: got v=%b instr=%h drops=%0d rdy=%b pc=%h want v=0 instr=0000 drops=2 rdy=1 pc=0030",
               ov[0], o_instr[0], fd0, ir[0], o_pc[0]);
    else npass++;
    for (int i = 0; i < 3; i++) begin
      ntot++;
      if (obs[i] !== exp_vec(i)) $display("FAIL flush_full dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      else npass++;
    end
  endtask

  task automatic test_flush_one();
    rst_pulse();
    drive(1'b1, 16'h0040, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0042, 1'b1, 1'b1);
    tick();
    ntot++;
    if (ov[0] !== 1'b0 || fd0 !== 8'd1 || o_pc[0] !== 16'h0040 || o_instr[0] !== 16'h0000)
      $display("FAIL flush_one: got v=%b drops=%0d pc=%h instr=%h want v=0 drops=1 pc=0040 instr=0000",
               ov[0], fd0, o_pc[0], o_instr[0]);
    else npass++;
    for (int i = 0; i < 3; i++) begin
      ntot++;
      if (obs[i] !== exp_vec(i)) $display("FAIL flush_one dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      else npass++;
    end
  endtask

  task automatic test_saturate();
    rst_pulse();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 16'(16'h0050 + k), 1'b0, 1'b0);
      tick();
      drive(1'b0, 16'h0000, 1'b0, 1'b1);
      tick();
      ntot++;
      if (fd2 !== 2'((k > 3) ? 3 : k) || fd0 !== 8'(k))
        $display("FAIL saturate[%0d]: got cnt2=%0d cnt8=%0d want cnt2=%0d cnt8=%0d", k, fd2, fd0, (k > 3) ? 3 : k, k);
      else npass++;
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    rst_pulse();
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      in_instr = 16'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        ntot++;
        if (obs[i] !== exp_vec(i)) $display("FAIL random[%0d] dut%0d: got %h want %h", k, i, obs[i], exp_vec(i));
        else npass++;
      end
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    rst_pulse();
    drive(1'b1, 16'h0020, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h0022, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    ntot++;
    if (ir[1] !== 1'b0 || ov[1] !== 1'b1 || fd1 !== 8'd1)
      $display("FAIL noskid_stall: got rdy=%b v=%b drops=%0d want rdy=0 v=1 drops=1", ir[1], ov[1], fd1);
    else npass++;
    #2;
    rst = 1'b0;
    #1;
    ntot++;
    if (ov !== 3'b000 || o_instr[1] !== 16'h0000 || fd1 !== 8'd0 || ir[1] !== 1'b1)
      $display("FAIL reset_mid: got v=%b instr=%h drops=%0d rdy=%b want v=000 instr=0000 drops=0 rdy=1",
               ov, o_instr[1], fd1, ir[1]);
    else npass++;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ntot++;
      if (obs[i] !== exp_vec(i)) $display("FAIL reset_mid dut%0d: got %h want %h", i, obs[i], exp_vec(i));
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_flush_one();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
